// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data memory controller: access-size codes,
// controller states, byte-enable generation and load lane extraction.
package dmem_pkg;

  typedef enum logic [2:0] {
    DM_B  = 3'b000,
    DM_H  = 3'b001,
    DM_W  = 3'b010,
    DM_BU = 3'b100,
    DM_HU = 3'b101
  } dmctrl_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // True for the five defined access codes.
  function automatic logic ctrl_legal(input logic [2:0] ctrl);
    logic ok;
    case (ctrl)
      DM_B, DM_H, DM_W, DM_BU, DM_HU: ok = 1'b1;
      default:                        ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Byte lanes touched by an access; halfwords and words ignore the low
  // offset bits so misaligned accesses land on the aligned-down lanes.
  function automatic logic [3:0] be_from_ctrl(input logic [2:0] ctrl,
                                              input logic [1:0] off);
    logic [3:0] be;
    case (ctrl)
      DM_B, DM_BU: be = 4'b0001 << off;
      DM_H, DM_HU: be = off[1] ? 4'b1100 : 4'b0011;
      DM_W:        be = 4'b1111;
      default:     be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicate right-aligned store data across every lane it could occupy,
  // so the byte enables alone pick the destination.
  function automatic logic [31:0] store_align(input logic [31:0] data,
                                              input logic [2:0]  ctrl);
    logic [31:0] w;
    case (ctrl)
      DM_B, DM_BU: w = {4{data[7:0]}};
      DM_H, DM_HU: w = {2{data[15:0]}};
      default:     w = data;
    endcase
    return w;
  endfunction

  // Shift the addressed lane down and sign- or zero-extend it.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [2:0]  ctrl,
                                               input logic [1:0]  off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (ctrl)
      DM_B:    r = {{24{b[7]}}, b};
      DM_BU:   r = {24'b0, b};
      DM_H:    r = {{16{h[15]}}, h};
      DM_HU:   r = {16'b0, h};
      DM_W:    r = word;
      default: r = 32'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_ram_be.sv
// Single-port, word-wide synchronous RAM with per-byte write enables.
// Read data is registered and updates only on enabled cycles, so it holds
// steady while the controller presents a response.
module dmem_ram_be #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [3:0]            we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem_q [2**ADDR_WIDTH];
  logic [31:0] rdata_q;

  // Enabled cycle: write the selected lanes and capture the addressed word.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_memory_ctrl.sv
// Data memory controller: single-outstanding request/response front end with
// WAIT_STATES wait cycles in front of a byte-enable RAM.
// Optional feature macro DMCTRL_FAULT_EN: misaligned, illegal and
// out-of-range accesses raise Fault; without it Fault is tied low,
// misaligned accesses align down and addresses wrap modulo the depth.
module data_memory_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic [31:0] Address,
  input  logic [31:0] DataWr,
  input  logic        DMWr,
  input  logic [2:0]  DMCtrl,
  output logic        RspValid,
  input  logic        RspReady,
  output logic [31:0] DataRd,
  output logic        Fault
);

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  ready_q, ready_d;
  logic                  wr_q, wr_d;
  logic [2:0]            ctrl_q, ctrl_d;
  logic                  bad_q, bad_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [1:0]            off_q, off_d;
  logic [31:0]           wdata_q, wdata_d;

  logic                  bad_live;
  logic                  ram_en;
  logic [3:0]            ram_we;
  logic [31:0]           ram_wdata;
  logic [31:0]           ram_rdata;

`ifdef DMCTRL_FAULT_EN
  logic hi_nonzero;
  logic misaligned;
  assign hi_nonzero = (Address >> (ADDR_WIDTH + 2)) != 32'b0;
  assign misaligned = (((DMCtrl == DM_H) || (DMCtrl == DM_HU)) && Address[0]) ||
                      ((DMCtrl == DM_W) && (Address[1:0] != 2'b00));
  assign bad_live   = !ctrl_legal(DMCtrl) || misaligned || hi_nonzero;
`else
  // Upper address bits only matter for range faulting.
  logic unused_addr_hi;
  assign unused_addr_hi = ^(Address >> (ADDR_WIDTH + 2));
  assign bad_live       = !ctrl_legal(DMCtrl);
`endif

  // Next-state logic: accept in IDLE, count wait states, hold the response.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    ctrl_d  = ctrl_q;
    bad_d   = bad_q;
    idx_d   = idx_q;
    off_d   = off_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (ReqValid && ready_q) begin
          wr_d    = DMWr;
          ctrl_d  = DMCtrl;
          bad_d   = bad_live;
          idx_d   = Address[ADDR_WIDTH+1:2];
          off_d   = Address[1:0];
          wdata_d = DataWr;
          if (WAIT_STATES == 0) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = 4'(WAIT_STATES - 1);
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_RESP: begin
        if (RspReady) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Registered so that ReqReady is low while reset is held and during the
    // cycle a response retires.
    ready_d = (state_d == ST_IDLE);
  end

  // RAM access happens on the edge entering RESP; the _d values carry the
  // live request when zero wait states skip the latch stage.
  always_comb begin
    ram_en    = (state_d == ST_RESP) && (state_q != ST_RESP);
    ram_we    = (ram_en && wr_d && !bad_d) ? be_from_ctrl(ctrl_d, off_d) : 4'b0000;
    ram_wdata = store_align(wdata_d, ctrl_d);
  end

  // Control state with asynchronous reset.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      ready_q <= 1'b0;
      wr_q    <= 1'b0;
      ctrl_q  <= 3'b000;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      wr_q    <= wr_d;
      ctrl_q  <= ctrl_d;
      bad_q   <= bad_d;
    end
  end

  // Request payload; only meaningful while a transaction is in flight.
  always_ff @(posedge Clk) begin
    idx_q   <= idx_d;
    off_q   <= off_d;
    wdata_q <= wdata_d;
  end

  dmem_ram_be #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk  (Clk),
    .en   (ram_en),
    .we   (ram_we),
    .addr (idx_d),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

  assign ReqReady = ready_q;
  assign RspValid = (state_q == ST_RESP);
  assign DataRd   = (RspValid && !wr_q && !bad_q) ?
                    load_extract(ram_rdata, ctrl_q, off_q) : 32'b0;
`ifdef DMCTRL_FAULT_EN
  assign Fault    = RspValid && bad_q;
`else
  assign Fault    = 1'b0;
`endif

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Self-checking bench for data_memory_ctrl: directed transactions with
// literal expectations plus randomized traffic compared every cycle against
// a transaction-level memory model.
module tb_data_memory_ctrl;

  localparam int AW    = 10;
  localparam int WS    = 1;
  localparam int DEPTH = 1 << AW;
`ifdef DMCTRL_FAULT_EN
  localparam logic FEN = 1'b1;
`else
  localparam logic FEN = 1'b0;
`endif
  localparam logic [2:0] C_B = 3'b000, C_H = 3'b001, C_W = 3'b010,
                         C_BU = 3'b100, C_HU = 3'b101;

  logic        Clk = 1'b0, Rst_n = 1'b0;
  logic        ReqValid = 1'b0, ReqReady;
  logic [31:0] Address = '0, DataWr = '0, DataRd;
  logic        DMWr = 1'b0;
  logic [2:0]  DMCtrl = '0;
  logic        RspValid, RspReady = 1'b1, Fault;

  int n_total = 0;
  int n_pass  = 0;

  data_memory_ctrl #(.ADDR_WIDTH(AW), .WAIT_STATES(WS)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .ReqValid(ReqValid), .ReqReady(ReqReady),
    .Address(Address), .DataWr(DataWr), .DMWr(DMWr), .DMCtrl(DMCtrl),
    .RspValid(RspValid), .RspReady(RspReady), .DataRd(DataRd), .Fault(Fault)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at %0t", name, got, exp, $time);
  endtask

  // Memory model: word index -> contents.
  logic [31:0] mm [int];

  function automatic void mdl_exec(input logic [31:0] a, input logic [31:0] d,
                                   input logic wr, input logic [2:0] c,
                                   output logic [31:0] rd, output logic flt);
    int size, idx, off;
    logic sgn, bad;
    logic [31:0] w, u, mask;
    sgn = 1'b0;
    case (c)
      3'b000: begin size = 1; sgn = 1'b1; end
      3'b100: size = 1;
      3'b001: begin size = 2; sgn = 1'b1; end
      3'b101: size = 2;
      3'b010: size = 4;
      default: size = 0;
    endcase
    idx = int'((a >> 2) % DEPTH);
    off = int'(a % 4);
    bad = (size == 0);
    if (FEN && !bad && (((a % size) != 0) || (a >= 32'(4 * DEPTH)))) bad = 1'b1;
    flt = FEN && bad;
    rd  = 32'b0;
    if (!bad) begin
      off = off - (off % size);
      w   = mm.exists(idx) ? mm[idx] : 'x;
      if (wr) begin
        for (int k = 0; k < size; k++) w[8*(off+k) +: 8] = d[8*k +: 8];
        mm[idx] = w;
      end else begin
        mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
        u = (w >> (8 * off)) & mask;
        if (sgn && u[8*size-1]) u = u | ~mask;
        rd = u;
      end
    end
  endfunction

  // Expected outputs for the current cycle, advanced at each falling edge.
  logic        e_rdy = 1'b0, e_vld = 1'b0, pend = 1'b0, e_flt = 1'b0;
  logic [31:0] e_data = '0;
  int          rem = 0;
  logic [31:0] p_a, p_d;
  logic        p_wr;
  logic [2:0]  p_c;

  // Per-cycle comparison against the model, then advance the model.
  always @(negedge Clk) begin
    if (!Rst_n) begin
      chk("rst_ReqReady", 32'(ReqReady), 32'd0);
      chk("rst_RspValid", 32'(RspValid), 32'd0);
      chk("rst_DataRd",   DataRd,        32'd0);
      chk("rst_Fault",    32'(Fault),    32'd0);
      e_rdy = 1'b0; e_vld = 1'b0; pend = 1'b0;
    end else begin
      chk("ReqReady", 32'(ReqReady), 32'(e_rdy));
      chk("RspValid", 32'(RspValid), 32'(e_vld));
      if (e_vld) begin
        chk("DataRd", DataRd,     e_data);
        chk("Fault",  32'(Fault), 32'(e_flt));
      end
      if (e_vld) begin
        if (RspReady) begin e_vld = 1'b0; e_rdy = 1'b1; end
      end else if (e_rdy) begin
        if (ReqValid) begin
          e_rdy = 1'b0; pend = 1'b1; rem = WS + 1;
          p_a = Address; p_d = DataWr; p_wr = DMWr; p_c = DMCtrl;
        end
      end else if (!pend) begin
        e_rdy = 1'b1;
      end
      if (pend) begin
        rem--;
        if (rem == 0) begin
          pend  = 1'b0;
          e_vld = 1'b1;
          mdl_exec(p_a, p_d, p_wr, p_c, e_data, e_flt);
        end
      end
    end
  end

  task automatic txn(input logic [31:0] a, input logic [31:0] d, input logic wr,
                     input logic [2:0] c, input int hold,
                     output logic [31:0] rd, output logic flt, output int lat);
    int t;
    rd = '0; flt = 1'b0; lat = -1;
    @(posedge Clk); #1;
    ReqValid = 1'b1; Address = a; DataWr = d; DMWr = wr; DMCtrl = c;
    RspReady = (hold == 0);
    t = 0;
    @(negedge Clk);
    while (!ReqReady && t < 50) begin @(negedge Clk); t++; end
    if (!ReqReady) begin
      chk("accept_timeout", 32'(ReqReady), 32'd1);
      ReqValid = 1'b0;
      return;
    end
    lat = 0;
    do begin
      @(posedge Clk); #1;
      ReqValid = 1'b0; Address = $urandom; DataWr = $urandom;
      DMWr = 1'($urandom); DMCtrl = 3'($urandom);
      @(negedge Clk);
      lat++;
    end while (!RspValid && lat < 40);
    if (!RspValid) begin
      chk("rsp_timeout", 32'(RspValid), 32'd1);
      RspReady = 1'b1;
      return;
    end
    rd = DataRd; flt = Fault;
    if (hold > 0) begin
      repeat (hold) begin
        @(negedge Clk);
        chk("hold_data",  DataRd,        rd);
        chk("hold_ready", 32'(ReqReady), 32'd0);
      end
      @(posedge Clk); #1;
      RspReady = 1'b1;
    end
  endtask

  logic [31:0] rd, a, d;
  logic        flt, seen;
  int          lat, t;
  logic [2:0]  codes [10] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101,
                              3'b000, 3'b001, 3'b010, 3'b110, 3'b011};

  initial begin
    repeat (3) @(posedge Clk);
    #1 Rst_n = 1'b1;

    for (int i = 0; i < 16; i++) txn(32'(i * 4), 32'h1234_5600 + 32'(i), 1'b1, C_W, 0, rd, flt, lat);

    txn(32'h10, 32'hDEAD_BEEF, 1'b1, C_W, 0, rd, flt, lat);
    chk("sw_lat", 32'(lat), 32'(WS + 1));
    chk("sw_data_zero", rd, 32'h0);
    txn(32'h10, 32'h0, 1'b0, C_W, 0, rd, flt, lat);
    chk("lw_lat", 32'(lat), 32'(WS + 1));
    chk("lw_10", rd, 32'hDEAD_BEEF);

    txn(32'h11, 32'h7F, 1'b1, C_B, 0, rd, flt, lat);
    txn(32'h11, 32'h0, 1'b0, C_B, 0, rd, flt, lat);   chk("lb_11", rd, 32'h0000_007F);
    txn(32'h10, 32'h0, 1'b0, C_W, 0, rd, flt, lat);   chk("lw_10_sb", rd, 32'hDEAD_7FEF);
    txn(32'h13, 32'h0, 1'b0, C_BU, 0, rd, flt, lat);  chk("lbu_13", rd, 32'h0000_00DE);
    txn(32'h13, 32'h0, 1'b0, C_B, 0, rd, flt, lat);   chk("lb_13", rd, 32'hFFFF_FFDE);

    txn(32'h22, 32'h8001, 1'b1, C_H, 0, rd, flt, lat);
    txn(32'h22, 32'h0, 1'b0, C_H, 0, rd, flt, lat);   chk("lh_22", rd, 32'hFFFF_8001);
    txn(32'h22, 32'h0, 1'b0, C_HU, 0, rd, flt, lat);  chk("lhu_22", rd, 32'h0000_8001);
    txn(32'h20, 32'h0, 1'b0, C_W, 0, rd, flt, lat);   chk("lw_20", rd, 32'h8001_5608);

    // Backpressure for five cycles.
    txn(32'h10, 32'h0, 1'b0, C_W, 5, rd, flt, lat);
    chk("bp_data", rd, 32'hDEAD_7FEF);
    @(negedge Clk);
    chk("bp_last_valid", 32'(RspValid), 32'd1);
    @(negedge Clk);
    chk("bp_idle_valid", 32'(RspValid), 32'd0);
    chk("bp_idle_ready", 32'(ReqReady), 32'd1);

    // Reset during the wait state of a load.
    @(posedge Clk); #1;
    ReqValid = 1'b1; Address = 32'h10; DMWr = 1'b0; DMCtrl = C_W; RspReady = 1'b1;
    t = 0;
    @(negedge Clk);
    while (!ReqReady && t < 50) begin @(negedge Clk); t++; end
    chk("rst_seq_accept", 32'(ReqReady), 32'd1);
    @(posedge Clk); #1;
    ReqValid = 1'b0;
    Rst_n = 1'b0;
    @(negedge Clk);
    chk("rst_mid_valid", 32'(RspValid), 32'd0);
    chk("rst_mid_ready", 32'(ReqReady), 32'd0);
    @(posedge Clk); #1 Rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin @(negedge Clk); seen = seen | RspValid; end
    chk("rst_no_rsp", 32'(seen), 32'd0);
    txn(32'h10, 32'h0, 1'b0, C_W, 0, rd, flt, lat);
    chk("rst_next_lw", rd, 32'hDEAD_7FEF);
    chk("rst_next_lat", 32'(lat), 32'(WS + 1));

    // Misaligned, out-of-range and illegal accesses.
    txn(32'h12, 32'h0, 1'b0, C_W, 0, rd, flt, lat);
    chk("lw_12_fault", 32'(flt), 32'(FEN));
    chk("lw_12_data", rd, FEN ? 32'h0 : 32'hDEAD_7FEF);
    txn(32'h1000, 32'hCAFE_F00D, 1'b1, C_W, 0, rd, flt, lat);
    chk("sw_1000_fault", 32'(flt), 32'(FEN));
    txn(32'h0, 32'h0, 1'b0, C_W, 0, rd, flt, lat);
    chk("lw_0", rd, FEN ? 32'h1234_5600 : 32'hCAFE_F00D);
    txn(32'h10, 32'hFFFF_FFFF, 1'b1, 3'b011, 0, rd, flt, lat);
    chk("illegal_data", rd, 32'h0);
    chk("illegal_fault", 32'(flt), 32'(FEN));
    txn(32'h10, 32'h0, 1'b0, C_W, 0, rd, flt, lat);
    chk("illegal_nowrite", rd, 32'hDEAD_7FEF);

    // Randomized traffic within a 16-word window.
    for (int n = 0; n < 300; n++) begin
      a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) a = a | (32'($urandom) << 12);
      d = $urandom;
      txn(a, d, 1'($urandom), codes[$urandom_range(0, 9)], $urandom_range(0, 2), rd, flt, lat);
      chk("rand_lat", 32'(lat), 32'(WS + 1));
      repeat ($urandom_range(0, 2)) @(posedge Clk);
    end

    repeat (3) @(negedge Clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
- Synchronous, parametrised successor to the combinational data memory.
- Clocked word-organised RAM behind a single-outstanding request/response handshake, with a configurable number of wait states.
- Supports byte, halfword and word loads and stores, with sign or zero extension.
- Sits between the processor's memory stage and the data RAM; lets multicycle and pipelined cores stall on memory.

Parameters:
- ADDR_WIDTH, 10, word-address bits; depth = 2^ADDR_WIDTH 32-bit words (4 KB at default).
- WAIT_STATES, 1, extra cycles between accept and response; legal range 0..15.

Ports:
- Clk  in  1  clock, rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- ReqValid  in  1  request present.
- ReqReady  out  1  controller can accept a request.
- Address  in  32  byte address.
- DataWr  in  32  store data, right-aligned (byte in [7:0], halfword in [15:0]).
- DMWr  in  1  1 = store, 0 = load.
- DMCtrl  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU; other codes are illegal.
- RspValid  out  1  response present.
- RspReady  in  1  consumer takes the response.
- DataRd  out  32  load result, extended per DMCtrl; 0 for stores.
- Fault  out  1  response is an error; qualified by RspValid.

Behaviour:
- Reset values: ReqReady=0, RspValid=0, DataRd=0, Fault=0, FSM in IDLE. RAM contents are not reset.
- Reset is asynchronous. Asserting Rst_n mid-operation abandons the transaction. A store already committed stays committed; no response is produced.
- FSM states:
  - IDLE (ReqReady=1): ReqValid&ReqReady latches Address, DataWr, DMWr, DMCtrl. Next state is WAIT if WAIT_STATES>0, else RESP.
  - WAIT: 4-bit counter loaded with WAIT_STATES-1 at accept, decrements each cycle; at 0 go to RESP.
  - RESP (RspValid=1, DataRd/Fault stable): stay until RspReady=1, then go to IDLE.
- Latency: RspValid rises exactly WAIT_STATES+1 cycles after the accept edge. Back-to-back throughput is one transaction per WAIT_STATES+2 cycles when RspReady is held at 1.
- ReqReady=0 outside IDLE. New requests are not accepted in the cycle RESP retires.
- Store commit: the RAM write occurs at the edge entering RESP, with byte enables derived from DMCtrl and Address[1:0]:
  - SB: one lane, selected by Address[1:0].
  - SH: lanes [1:0] or [3:2], selected by Address[1].
  - SW: all four lanes.
- Load read: the RAM is read at the edge entering RESP. The addressed lane is shifted down, then sign-extended (B/H) or zero-extended (BU/HU).
- Store-then-load to the same word returns the new data, because the store has committed before the next request can be accepted.
- Illegal DMCtrl: no write occurs, DataRd=0, and the response is still produced. Fault=1 only when DMCTRL_FAULT_EN is defined.
- Word index is Address[ADDR_WIDTH+1:2]. Upper address bits are ignored unless DMCTRL_FAULT_EN is defined.

Optional Feature:
- Macro: DMCTRL_FAULT_EN.
- Defined: a fault is raised for any of:
  - halfword access with Address[0]=1;
  - word access with Address[1:0]!=0;
  - illegal DMCtrl;
  - Address[31:ADDR_WIDTH+2]!=0.
  On a fault: no RAM write, DataRd=0, Fault=1 in RESP, and latency is unchanged.
- Undefined: Fault is tied 0. Misaligned halfword and word accesses ignore the low offending bits (aligned down). Out-of-range addresses wrap modulo the depth.

Decomposition:
- Package dmem_pkg holds:
  - dmctrl_e enum for DMCtrl codes (B, H, W, BU, HU);
  - FSM state enum (IDLE, WAIT, RESP);
  - function be_from_ctrl (byte enables);
  - function load_extract (lane select and extension).
- Sub-module dmem_ram_be: single-port, word-wide, byte-enable synchronous RAM with parameter ADDR_WIDTH. The controller instantiates it.

Test Plan:
- WAIT_STATES=1: SW 0xDEADBEEF @0x10, then LW @0x10 -> RspValid 2 cycles after each accept, DataRd=0xDEADBEEF.
- After the above, SB 0x7F @0x11, then LB @0x11 -> 0x0000007F; LW @0x10 -> 0xDEAD7FEF; LBU @0x13 -> 0x000000DE; LB @0x13 -> 0xFFFFFFDE.
- SH 0x8001 @0x22, then LH @0x22 -> 0xFFFF8001; LHU @0x22 -> 0x00008001; LW @0x20 -> upper half 0x8001, lower half unchanged.
- Backpressure: hold RspReady=0 for 5 cycles -> RspValid and DataRd stay stable and ReqReady stays 0; RspReady=1 -> IDLE the next cycle.
- Rst_n pulsed low during WAIT of an LW -> outputs return to reset values immediately, no RspValid follows, and the next request completes normally.
- With DMCTRL_FAULT_EN defined: LW @0x12 -> Fault=1, DataRd=0; SW @0x1000 (ADDR_WIDTH=10) -> Fault=1 and a subsequent LW @0x0 is unchanged. Without the macro: LW @0x12 returns the word at 0x10.
